// File: rtl/hilo_unit.sv
// hilo_unit -- architectural HI/LO register pair with a mult/div latency tracker.
//
// Captures the ALU's hi/lo results when a mult or div issues, holds them as a
// pending result for MULT_LATENCY or DIV_LATENCY cycles, then commits them to
// the architectural HI/LO registers. While an operation is in flight, any
// mfhi/mflo/mult/div request stalls the EX stage and everything upstream.
//
// Ports:
//   i_clk           pipeline clock
//   i_reset         synchronous, active-high reset
//   i_start_mult    EX issues mult this cycle (wins over i_start_div)
//   i_start_div     EX issues div this cycle
//   i_alu_hi/lo     ALU hi/lo results, captured on an accepted start
//   i_divisor       ALU src_b, used for divide-by-zero detection
//   i_read_hi/lo    mfhi/mflo in EX this cycle
//   i_flush         squash EX and any in-flight operation
//   o_busy          operation in flight (registered)
//   o_stall         hold EX and upstream (combinational)
//   o_hi_out/lo_out committed HI/LO (no forwarding from the pending result)
//   o_div_zero      one-cycle pulse: a divide by zero retired
//   o_dbg_state     current FSM state (0 = IDLE, 1 = BUSY)
//
// Handshake: a start is accepted only in IDLE without a same-cycle flush.
// Starts presented while BUSY are ignored and raise o_stall; the requester
// must hold them until o_stall drops, at which point they are accepted.
module hilo_unit #(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start_mult,
  input  logic        i_start_div,
  input  logic [31:0] i_alu_hi,
  input  logic [31:0] i_alu_lo,
  input  logic [31:0] i_divisor,
  input  logic        i_read_hi,
  input  logic        i_read_lo,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_stall,
  output logic [31:0] o_hi_out,
  output logic [31:0] o_lo_out,
  output logic        o_div_zero,
  output logic        o_dbg_state
);

  localparam int MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
  // Counter holds at most MAX_LAT-1; never narrower than 5 bits.
  localparam int CW = ($clog2(MAX_LAT) < 5) ? 5 : $clog2(MAX_LAT);
  localparam logic [CW-1:0] MULT_INIT = CW'(MULT_LATENCY - 1);
  localparam logic [CW-1:0] DIV_INIT  = CW'(DIV_LATENCY - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_next_count;
  logic          w_accept;
  logic          w_accept_div;
  logic          w_commit;
  logic          w_retire_zero;

  logic [31:0]   r_pend_hi;
  logic [31:0]   r_pend_lo;
  logic          r_zero_pend;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic          r_div_zero;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state  = r_state;
    w_next_count  = r_count;
    w_accept      = 1'b0;
    w_accept_div  = 1'b0;
    w_commit      = 1'b0;
    w_retire_zero = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Flush squashes the instruction in EX, including its start.
        if (!i_flush) begin
          if (i_start_mult) begin
            w_accept     = 1'b1;
            w_next_count = MULT_INIT;
            w_next_state = S_BUSY;
          end else if (i_start_div) begin
            w_accept     = 1'b1;
            w_accept_div = 1'b1;
            w_next_count = DIV_INIT;
            w_next_state = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (i_flush) begin
          w_next_state = S_IDLE;
          w_next_count = '0;
        end else if (r_count == '0) begin
          w_next_state = S_IDLE;
          // A divide by zero leaves HI/LO alone and reports instead.
          if (r_zero_pend) w_retire_zero = 1'b1;
          else             w_commit      = 1'b1;
        end else begin
          w_next_count = r_count - 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_count = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    o_busy      = (r_state == S_BUSY);
    o_stall     = o_busy & (i_read_hi | i_read_lo | i_start_mult | i_start_div);
    o_dbg_state = r_state;
  end

  // Pending / committed datapath
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend_hi   <= '0;
      r_pend_lo   <= '0;
      r_zero_pend <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      r_div_zero <= w_retire_zero;
      if (w_accept) begin
        r_pend_hi   <= i_alu_hi;
        r_pend_lo   <= i_alu_lo;
        r_zero_pend <= w_accept_div & (i_divisor == 32'd0);
      end
      if (w_commit) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end
  end

  assign o_hi_out   = r_hi;
  assign o_lo_out   = r_lo;
  assign o_div_zero = r_div_zero;

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;

  localparam int ML = 4;
  localparam int DL = 32;

  // Clock / reset
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_reset, i_start_mult, i_start_div, i_read_hi, i_read_lo, i_flush;
  logic [31:0] i_alu_hi, i_alu_lo, i_divisor;
  logic        o_busy, o_stall, o_div_zero, o_dbg_state;
  logic [31:0] o_hi_out, o_lo_out;

  hilo_unit #(.MULT_LATENCY(ML), .DIV_LATENCY(DL)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start_mult(i_start_mult),
    .i_start_div (i_start_div),
    .i_alu_hi    (i_alu_hi),
    .i_alu_lo    (i_alu_lo),
    .i_divisor   (i_divisor),
    .i_read_hi   (i_read_hi),
    .i_read_lo   (i_read_lo),
    .i_flush     (i_flush),
    .o_busy      (o_busy),
    .o_stall     (o_stall),
    .o_hi_out    (o_hi_out),
    .o_lo_out    (o_lo_out),
    .o_div_zero  (o_div_zero),
    .o_dbg_state (o_dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit g_chk = 1'b0;

  // Reference model: cycles of busy remaining, a pending result, committed HI/LO.
  int          m_rem = 0;
  logic [31:0] m_ph = '0, m_pl = '0, m_hi = '0, m_lo = '0;
  bit          m_zero = 1'b0, m_dz = 1'b0;

  // Outputs captured at the most recent sample point
  logic        s_busy, s_stall, s_dz;
  logic [31:0] s_hi, s_lo;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, check outputs mid-cycle against the model, then advance
  // the model across the rising edge.
  task automatic step(input logic sm, input logic sd, input logic [31:0] ah,
                      input logic [31:0] al, input logic [31:0] dv,
                      input logic rh, input logic rl, input logic fl, input logic rst);
    bit e_busy;
    @(negedge i_clk);
    i_start_mult = sm; i_start_div = sd; i_alu_hi = ah; i_alu_lo = al;
    i_divisor = dv; i_read_hi = rh; i_read_lo = rl; i_flush = fl; i_reset = rst;
    #1;
    s_busy = o_busy; s_stall = o_stall; s_dz = o_div_zero; s_hi = o_hi_out; s_lo = o_lo_out;
    e_busy = (m_rem > 0);
    if (g_chk) begin
      chk("busy",     {31'd0, s_busy},  {31'd0, e_busy});
      chk("stall",    {31'd0, s_stall}, {31'd0, e_busy & (rh | rl | sm | sd)});
      chk("div_zero", {31'd0, s_dz},    {31'd0, m_dz});
      chk("hi_out",   s_hi, m_hi);
      chk("lo_out",   s_lo, m_lo);
    end
    @(posedge i_clk);
    if (rst) begin
      m_rem = 0; m_ph = '0; m_pl = '0; m_hi = '0; m_lo = '0; m_zero = 1'b0; m_dz = 1'b0;
      g_chk = 1'b1;
    end else begin
      m_dz = 1'b0;
      if (m_rem > 0) begin
        if (fl) m_rem = 0;
        else if (m_rem == 1) begin
          if (m_zero) m_dz = 1'b1;
          else begin m_hi = m_ph; m_lo = m_pl; end
          m_rem = 0;
        end else m_rem = m_rem - 1;
      end else if (!fl && (sm || sd)) begin
        m_rem  = sm ? ML : DL;
        m_ph   = ah;
        m_pl   = al;
        m_zero = !sm && (dv == 32'd0);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, '0, 32'd1, 0, 0, 0, 0);
  endtask

  initial begin
    i_reset = 1'b1; i_start_mult = 0; i_start_div = 0; i_alu_hi = '0; i_alu_lo = '0;
    i_divisor = 32'd1; i_read_hi = 0; i_read_lo = 0; i_flush = 0;

    // Reset, then idle
    step(0, 0, '0, '0, 32'd1, 0, 0, 0, 1);
    step(0, 0, '0, '0, 32'd1, 0, 0, 0, 1);
    step(0, 0, '0, '0, 32'd1, 1, 1, 0, 0);
    chk("rst_busy", {31'd0, s_busy}, 32'd0);
    chk("rst_stall", {31'd0, s_stall}, 32'd0);
    chk("rst_hi", s_hi, 32'd0);
    chk("rst_lo", s_lo, 32'd0);
    chk("rst_dz", {31'd0, s_dz}, 32'd0);

    // Mult: busy in cycles 1..4, result visible from cycle 5
    step(1, 0, 32'h0000_0001, 32'h8000_0000, 32'd1, 0, 0, 0, 0);   // cycle 0
    idle(2);                                                        // cycles 1,2
    step(0, 0, '0, '0, 32'd1, 1, 0, 0, 0);                          // cycle 3
    chk("mul_stall_c3", {31'd0, s_stall}, 32'd1);
    step(0, 0, '0, '0, 32'd1, 0, 0, 0, 0);                          // cycle 4
    chk("mul_busy_c4", {31'd0, s_busy}, 32'd1);
    chk("mul_hi_c4_old", s_hi, 32'd0);
    step(0, 0, '0, '0, 32'd1, 1, 0, 0, 0);                          // cycle 5
    chk("mul_stall_c5", {31'd0, s_stall}, 32'd0);
    chk("mul_busy_c5", {31'd0, s_busy}, 32'd0);
    chk("mul_hi", s_hi, 32'h0000_0001);
    chk("mul_lo", s_lo, 32'h8000_0000);

    // Div: busy 1..32, result from 33; mult in cycle 10 stalls and is ignored
    step(0, 1, 32'd3, 32'd7, 32'd5, 0, 0, 0, 0);                    // cycle 0
    idle(9);                                                        // 1..9
    step(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0);    // 10
    chk("div_stall_c10", {31'd0, s_stall}, 32'd1);
    idle(22);                                                       // 11..32
    chk("div_busy_c32", {31'd0, s_busy}, 32'd1);
    idle(1);                                                        // 33
    chk("div_busy_c33", {31'd0, s_busy}, 32'd0);
    chk("div_hi", s_hi, 32'd3);
    chk("div_lo", s_lo, 32'd7);

    // Set HI=0xAAAA0000, then back-to-back divide by zero
    step(1, 0, 32'hAAAA_0000, 32'h0000_5555, 32'd1, 0, 0, 0, 0);    // cycle 0
    idle(ML);                                                       // 1..4
    step(0, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'd0, 0, 0, 0, 0);    // 5: accepted, no bubble
    chk("b2b_hi", s_hi, 32'hAAAA_0000);
    idle(DL);                                                       // 6..37
    chk("dz_before", {31'd0, s_dz}, 32'd0);
    idle(1);                                                        // 38
    chk("dz_pulse", {31'd0, s_dz}, 32'd1);
    chk("dz_hi_kept", s_hi, 32'hAAAA_0000);
    chk("dz_lo_kept", s_lo, 32'h0000_5555);
    idle(1);
    chk("dz_one_cycle", {31'd0, s_dz}, 32'd0);

    // Flush mid-mult, then flush together with a div start
    step(1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 32'd1, 0, 0, 0, 0);    // cycle 0
    idle(1);
    step(0, 0, '0, '0, 32'd1, 0, 0, 1, 0);                          // cycle 2
    idle(1);                                                        // cycle 3
    chk("flush_busy", {31'd0, s_busy}, 32'd0);
    idle(ML);
    chk("flush_hi_kept", s_hi, 32'hAAAA_0000);
    step(0, 1, 32'h1, 32'h2, 32'd4, 0, 0, 1, 0);
    idle(1);
    chk("flush_start_busy", {31'd0, s_busy}, 32'd0);

    // Reset in cycle 2 of a mult
    step(1, 0, 32'h0000_0077, 32'h0000_0088, 32'd1, 0, 0, 0, 0);    // cycle 0
    idle(1);
    step(0, 0, '0, '0, 32'd1, 0, 0, 0, 1);                          // cycle 2
    idle(1);                                                        // cycle 3
    chk("rstmid_busy", {31'd0, s_busy}, 32'd0);
    chk("rstmid_hi", s_hi, 32'd0);
    idle(ML + 1);
    chk("rstmid_no_commit", s_lo, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] dv;
      dv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom, $urandom, dv,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
